bcd4_seg7_display: RTL and testbench

- Converts four BCD digits (units, tens, hundreds, thousands) into four 7-segment patterns.
- Each segment pattern is registered on the system clock.
- Subsystem 3 of the display path. It sits between the BCD conversion stage, which supplies the digits and the `listo` (ready) flag, and the display multiplexer/pins.
- Purely per-digit combinational decode followed by one output register stage.

---
 rtl/seg7_pkg.sv | 40 ++++
 rtl/bcd_to_seg7.sv | 17 +
 rtl/bcd4_seg7_display.sv | 59 +++++
 tb/tb_bcd4_seg7_display.sv | 139 +++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types, active-low segment codes and the BCD -> 7-segment decode function.
package seg7_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;

  localparam int NUM_DIGITS = 4;

  // Active-low codes, bit order {g,f,e,d,c,b,a}
  localparam seg7_t SEG_0     = 7'h40;
  localparam seg7_t SEG_1     = 7'h79;
  localparam seg7_t SEG_2     = 7'h24;
  localparam seg7_t SEG_3     = 7'h30;
  localparam seg7_t SEG_4     = 7'h19;
  localparam seg7_t SEG_5     = 7'h12;
  localparam seg7_t SEG_6     = 7'h02;
  localparam seg7_t SEG_7     = 7'h78;
  localparam seg7_t SEG_8     = 7'h00;
  localparam seg7_t SEG_9     = 7'h10;
  localparam seg7_t SEG_BLANK = 7'h7F;

  function automatic seg7_t bcd_to_seg7(input bcd_t bcd);
    seg7_t seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational single-digit decoder; invalid BCD blanks. ACTIVE_LOW=0 inverts
// every bit for common-cathode displays.
module bcd_to_seg7
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  seg7_t w_seg_al;

  assign w_seg_al = seg7_pkg::bcd_to_seg7(i_bcd);
  assign o_seg    = ACTIVE_LOW ? w_seg_al : ~w_seg_al;

endmodule

// File: rtl/bcd4_seg7_display.sv
// Four-digit BCD to 7-segment decode with one output register stage.
// Optional macro SEG_LISTO_GATE_EN: registers load only on edges with listo=1.
module bcd4_seg7_display
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] unidades_input,
  input  logic [3:0] decenas_input,
  input  logic [3:0] centenas_input,
  input  logic [3:0] milesimas_input,
  input  logic       listo,
  output logic [6:0] seg_unidades,
  output logic [6:0] seg_decenas,
  output logic [6:0] seg_centenas,
  output logic [6:0] seg_milesimas
);

  localparam seg7_t BLANK = ACTIVE_LOW ? SEG_BLANK : seg7_t'(~SEG_BLANK);

  bcd_t  [NUM_DIGITS-1:0] w_bcd;
  seg7_t [NUM_DIGITS-1:0] w_seg;
  seg7_t [NUM_DIGITS-1:0] r_seg;
  logic                   w_load;

  assign w_bcd = {milesimas_input, centenas_input, decenas_input, unidades_input};

  generate
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
      bcd_to_seg7 #(.ACTIVE_LOW(ACTIVE_LOW)) u_dec (
        .i_bcd (w_bcd[g]),
        .o_seg (w_seg[g])
      );
    end
  endgenerate

`ifdef SEG_LISTO_GATE_EN
  assign w_load = listo;
`else
  // listo is deliberately ignored in this build
  logic w_unused_listo;
  assign w_unused_listo = listo;
  assign w_load         = 1'b1;
`endif

  // Single shared enable keeps all four digits captured on the same edge
  always_ff @(posedge clk) begin
    if (rst)         r_seg <= {NUM_DIGITS{BLANK}};
    else if (w_load) r_seg <= w_seg;
  end

  assign seg_unidades  = r_seg[0];
  assign seg_decenas   = r_seg[1];
  assign seg_centenas  = r_seg[2];
  assign seg_milesimas = r_seg[3];

endmodule

// File: tb/tb_bcd4_seg7_display.sv
// Self-checking bench for bcd4_seg7_display (ACTIVE_LOW=1): directed table,
// hand sequences for reset/listo corners, and randomized traffic vs a model.
module tb_bcd4_seg7_display;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] un, te, hu, th;
  logic       listo;
  logic [6:0] s_un, s_te, s_hu, s_th;

  int checks = 0;
  int errors = 0;

  bcd4_seg7_display #(.ACTIVE_LOW(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .unidades_input  (un),
    .decenas_input   (te),
    .centenas_input  (hu),
    .milesimas_input (th),
    .listo           (listo),
    .seg_unidades    (s_un),
    .seg_decenas     (s_te),
    .seg_centenas    (s_hu),
    .seg_milesimas   (s_th)
  );

  always #5 clk = ~clk;

  // Reference patterns straight from the decode table; anything >9 is blank
  logic [6:0] lut [0:9];
  initial begin
    lut[0] = 7'h40; lut[1] = 7'h79; lut[2] = 7'h24; lut[3] = 7'h30; lut[4] = 7'h19;
    lut[5] = 7'h12; lut[6] = 7'h02; lut[7] = 7'h78; lut[8] = 7'h00; lut[9] = 7'h10;
  end

  function automatic logic [6:0] ref_dec(input logic [3:0] d);
    return (d <= 4'd9) ? lut[d] : 7'h7F;
  endfunction

  function automatic logic [27:0] ref_all(input logic [3:0] a, b, c, d);
    return {ref_dec(a), ref_dec(b), ref_dec(c), ref_dec(d)};
  endfunction

  typedef struct {
    string       name;
    logic        rst;
    logic        listo;
    logic [3:0]  th, hu, te, un;
    logic [27:0] exp;   // {milesimas, centenas, decenas, unidades}
  } vec_t;

  vec_t vecs [9];

  task automatic drive(input logic r, input logic l, input logic [3:0] a, b, c, d);
    rst = r; listo = l; th = a; hu = b; te = c; un = d;
  endtask

  task automatic check(input string name, input logic [27:0] exp);
    logic [27:0] act;
    act = {s_th, s_hu, s_te, s_un};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h_%h_%h_%h expected %h_%h_%h_%h", name,
               act[27:21], act[20:14], act[13:7], act[6:0],
               exp[27:21], exp[20:14], exp[13:7], exp[6:0]);
    end
  endtask

  task automatic step_check(input string name, input logic [27:0] exp);
    @(posedge clk); #1;
    check(name, exp);
  endtask

  logic [27:0] model;

  initial begin
    vecs[0] = '{"reset",        1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, {4{7'h7F}}};
    vecs[1] = '{"zeros",        1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0, {4{7'h40}}};
    vecs[2] = '{"v7609",        1'b0, 1'b1, 4'd7, 4'd6, 4'd0, 4'd9, {7'h78, 7'h02, 7'h40, 7'h10}};
    vecs[3] = '{"v3193",        1'b0, 1'b1, 4'd3, 4'd1, 4'd9, 4'd3, {7'h30, 7'h79, 7'h10, 7'h30}};
    vecs[4] = '{"v0094",        1'b0, 1'b1, 4'd0, 4'd0, 4'd9, 4'd4, {7'h40, 7'h40, 7'h10, 7'h19}};
    vecs[5] = '{"invalid_bcd",  1'b0, 1'b1, 4'd8, 4'd5, 4'hF, 4'hA, {7'h00, 7'h12, 7'h7F, 7'h7F}};
    vecs[6] = '{"hold7609",     1'b0, 1'b1, 4'd7, 4'd6, 4'd0, 4'd9, {7'h78, 7'h02, 7'h40, 7'h10}};
    vecs[7] = '{"midrst",       1'b1, 1'b0, 4'd7, 4'd6, 4'd0, 4'd9, {4{7'h7F}}};
    vecs[8] = '{"after_rst",    1'b0, 1'b1, 4'd7, 4'd6, 4'd0, 4'd9, {7'h78, 7'h02, 7'h40, 7'h10}};

    drive(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].rst, vecs[i].listo, vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].un);
      step_check(vecs[i].name, vecs[i].exp);
    end

`ifdef SEG_LISTO_GATE_EN
    drive(1'b0, 1'b0, 4'd3, 4'd1, 4'd9, 4'd3);
    step_check("gate_hold", {7'h78, 7'h02, 7'h40, 7'h10});
    step_check("gate_hold2", {7'h78, 7'h02, 7'h40, 7'h10});
    drive(1'b0, 1'b1, 4'd3, 4'd1, 4'd9, 4'd3);
    step_check("gate_load", {7'h30, 7'h79, 7'h10, 7'h30});
    drive(1'b1, 1'b1, 4'd3, 4'd1, 4'd9, 4'd3);
    step_check("rst_and_listo", {4{7'h7F}});
    drive(1'b0, 1'b0, 4'd5, 4'd5, 4'd5, 4'd5);
    step_check("blank_until_listo", {4{7'h7F}});
`else
    drive(1'b0, 1'b0, 4'd3, 4'd1, 4'd9, 4'd3);
    step_check("listo_ignored", {7'h30, 7'h79, 7'h10, 7'h30});
    drive(1'b1, 1'b1, 4'd3, 4'd1, 4'd9, 4'd3);
    step_check("rst_and_listo", {4{7'h7F}});
    drive(1'b0, 1'b0, 4'd5, 4'd2, 4'd8, 4'd1);
    step_check("reload_after_rst", {7'h12, 7'h24, 7'h00, 7'h79});
`endif

    // Randomized traffic: model tracks what the registers should hold
    model = {s_th, s_hu, s_te, s_un};
    model = {7'h12, 7'h24, 7'h00, 7'h79};
`ifdef SEG_LISTO_GATE_EN
    model = {4{7'h7F}};
`endif
    for (int n = 0; n < 300; n++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      if (rst) model = {4{7'h7F}};
`ifdef SEG_LISTO_GATE_EN
      else if (listo) model = ref_all(th, hu, te, un);
`else
      else model = ref_all(th, hu, te, un);
`endif
      step_check("random", model);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
